// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings used by the external ALU and the
// issue stage, plus the alu_ctrl instruction-class encodings.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;

   localparam logic [1:0] CTRL_ADD   = 2'b00;  // load/store address
   localparam logic [1:0] CTRL_SUB   = 2'b01;  // branch compare
   localparam logic [1:0] CTRL_RTYPE = 2'b10;
   localparam logic [1:0] CTRL_ITYPE = 2'b11;

   // Shift ops only consume the low five bits of operand B
   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL);
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of instruction class + funct fields into an ALU
// opcode. Unsupported encodings fall back to ADD and raise illegal_o.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [1:0] alu_ctrl_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output logic [3:0] alu_op_o,
   output logic       illegal_o
);

   // Class decode; R-type and I-type share the funct3 table, only 000 differs
   always_comb begin
      alu_op_o  = ALU_ADD;
      illegal_o = 1'b0;
      case (alu_ctrl_i)
         CTRL_ADD: alu_op_o = ALU_ADD;
         CTRL_SUB: alu_op_o = ALU_SUB;
         default: begin
            case (funct3_i)
               3'b000: begin
                  // I-type has no SUB: f7b5 is part of the immediate there
                  if ((alu_ctrl_i == CTRL_RTYPE) && funct7b5_i)
                     alu_op_o = ALU_SUB;
               end
               3'b111: alu_op_o = ALU_AND;
               3'b110: alu_op_o = ALU_OR;
               3'b100: alu_op_o = ALU_XOR;
               3'b001: begin
                  if (!funct7b5_i) alu_op_o  = ALU_SLL;
                  else             illegal_o = 1'b1;
               end
               3'b101: begin
                  // f7b5=1 would be SRA, which this ALU does not implement
                  if (!funct7b5_i) alu_op_o  = ALU_SRL;
                  else             illegal_o = 1'b1;
               end
               default: illegal_o = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/ex_issue_stage.sv
// EX issue stage: S1 issue register drives the external ALU, S2 captures the
// ALU result for the EX/MEM handshake. Latency 2, full throughput.
// Optional feature: define ILLEGAL_OP_TRAP_EN to add illegal_o and force the
// result of illegally-encoded ops to zero.
module ex_issue_stage
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [1:0]  alu_ctrl_i,
   input  logic [2:0]  funct3_i,
   input  logic        funct7b5_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] rs1_val_i,
   input  logic [31:0] op2_val_i,
   output logic [3:0]  alu_op_o,
   output logic [31:0] alu_a_o,
   output logic [31:0] alu_b_o,
   input  logic [31:0] alu_result_i,
   input  logic        alu_zero_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_result_o,
   output logic        out_zero_o,
   output logic [4:0]  out_rd_o,
`ifdef ILLEGAL_OP_TRAP_EN
   output logic        illegal_o,
`endif
   input  logic        flush_i
);

   logic [3:0]  w_dec_op;
   logic        w_dec_ill;
   logic        w_s1_adv;
   logic        w_s1_move;

   logic        r_s1_valid;
   logic [3:0]  r_s1_op;
   logic [31:0] r_s1_a;
   logic [31:0] r_s1_b;
   logic [4:0]  r_s1_rd;

   logic        r_s2_valid;
   logic [31:0] r_s2_result;
   logic        r_s2_zero;
   logic [4:0]  r_s2_rd;

   alu_op_decode u_dec (
      .alu_ctrl_i (alu_ctrl_i),
      .funct3_i   (funct3_i),
      .funct7b5_i (funct7b5_i),
      .alu_op_o   (w_dec_op),
      .illegal_o  (w_dec_ill)
   );

   // S1 may hand off whenever S2 is empty or draining this cycle
   assign w_s1_adv   = !r_s2_valid || out_ready_i;
   assign in_ready_o = !r_s1_valid || w_s1_adv;
   // A flushed S1 entry must never reach S2
   assign w_s1_move  = w_s1_adv && r_s1_valid && !flush_i;

   // ALU drive comes from S1 only and is quiet when S1 is empty
   assign alu_op_o = r_s1_valid ? r_s1_op : 4'd0;
   assign alu_a_o  = r_s1_valid ? r_s1_a  : 32'd0;
   assign alu_b_o  = !r_s1_valid      ? 32'd0 :
                     is_shift(r_s1_op) ? {27'd0, r_s1_b[4:0]} : r_s1_b;

   assign out_valid_o  = r_s2_valid;
   assign out_result_o = r_s2_result;
   assign out_zero_o   = r_s2_zero;
   assign out_rd_o     = r_s2_rd;

`ifdef ILLEGAL_OP_TRAP_EN
   logic r_s1_ill;
   logic r_s2_ill;

   assign illegal_o = r_s2_valid && r_s2_ill;

   // Illegal tag travels with the entry through both stages
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_ill <= 1'b0;
         r_s2_ill <= 1'b0;
      end else begin
         if (!flush_i && in_ready_o && in_valid_i) r_s1_ill <= w_dec_ill;
         if (w_s1_adv) r_s2_ill <= w_s1_move && r_s1_ill;
      end
   end
`else
   logic w_unused_ill;
   assign w_unused_ill = w_dec_ill;
`endif

   // S1 issue register: flush beats accept, accept only when S1 frees up
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= 4'd0;
         r_s1_a     <= 32'd0;
         r_s1_b     <= 32'd0;
         r_s1_rd    <= 5'd0;
      end else if (flush_i) begin
         r_s1_valid <= 1'b0;
      end else if (in_ready_o) begin
         r_s1_valid <= in_valid_i;
         if (in_valid_i) begin
            r_s1_op <= w_dec_op;
            r_s1_a  <= rs1_val_i;
            r_s1_b  <= op2_val_i;
            r_s1_rd <= rd_i;
         end
      end
   end

   // S2 result register: captures ALU output on the S1->S2 edge, holds on stall
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s2_valid  <= 1'b0;
         r_s2_result <= 32'd0;
         r_s2_zero   <= 1'b0;
         r_s2_rd     <= 5'd0;
      end else if (w_s1_adv) begin
         r_s2_valid <= w_s1_move;
         if (w_s1_move) begin
`ifdef ILLEGAL_OP_TRAP_EN
            r_s2_result <= r_s1_ill ? 32'd0 : alu_result_i;
            r_s2_zero   <= r_s1_ill ? 1'b1  : alu_zero_i;
`else
            r_s2_result <= alu_result_i;
            r_s2_zero   <= alu_zero_i;
`endif
            r_s2_rd     <= r_s1_rd;
         end
      end
   end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage with a behavioural model of the external
// ALU. Covers decode, latency, stall/backpressure, flush, illegal ops, reset.
module tb_ex_issue_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [1:0]  alu_ctrl_i;
   logic [2:0]  funct3_i;
   logic        funct7b5_i;
   logic [4:0]  rd_i;
   logic [31:0] rs1_val_i;
   logic [31:0] op2_val_i;
   logic [3:0]  alu_op_o;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic [31:0] alu_result_i;
   logic        alu_zero_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_result_o;
   logic        out_zero_o;
   logic [4:0]  out_rd_o;
   logic        flush_i;
`ifdef ILLEGAL_OP_TRAP_EN
   logic        illegal_o;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] q_res[$];
   logic [4:0]  q_rd[$];

   always #5 clk = ~clk;

   ex_issue_stage dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .alu_ctrl_i   (alu_ctrl_i),
      .funct3_i     (funct3_i),
      .funct7b5_i   (funct7b5_i),
      .rd_i         (rd_i),
      .rs1_val_i    (rs1_val_i),
      .op2_val_i    (op2_val_i),
      .alu_op_o     (alu_op_o),
      .alu_a_o      (alu_a_o),
      .alu_b_o      (alu_b_o),
      .alu_result_i (alu_result_i),
      .alu_zero_i   (alu_zero_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_result_o (out_result_o),
      .out_zero_o   (out_zero_o),
      .out_rd_o     (out_rd_o),
`ifdef ILLEGAL_OP_TRAP_EN
      .illegal_o    (illegal_o),
`endif
      .flush_i      (flush_i)
   );

   // External ALU model
   always_comb begin
      case (alu_op_o)
         4'd0:    alu_result_i = alu_a_o + alu_b_o;
         4'd1:    alu_result_i = alu_a_o - alu_b_o;
         4'd2:    alu_result_i = alu_a_o & alu_b_o;
         4'd3:    alu_result_i = alu_a_o | alu_b_o;
         4'd4:    alu_result_i = alu_a_o ^ alu_b_o;
         4'd5:    alu_result_i = alu_a_o << alu_b_o[4:0];
         4'd6:    alu_result_i = alu_a_o >> alu_b_o[4:0];
         default: alu_result_i = 32'd0;
      endcase
      alu_zero_i = (alu_result_i == 32'd0);
   end

   // Record every completed downstream transfer (sampled mid-cycle)
   always @(negedge clk) begin
      if (!reset && out_valid_o && out_ready_i) begin
         q_res.push_back(out_result_o);
         q_rd.push_back(out_rd_o);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] ctrl, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      in_valid_i = 1'b1;
      alu_ctrl_i = ctrl;
      funct3_i   = f3;
      funct7b5_i = f7;
      rs1_val_i  = a;
      op2_val_i  = b;
      rd_i       = rd;
   endtask

   initial begin
      reset = 1'b1; in_valid_i = 1'b0; alu_ctrl_i = 2'd0; funct3_i = 3'd0;
      funct7b5_i = 1'b0; rd_i = 5'd0; rs1_val_i = 32'd0; op2_val_i = 32'd0;
      out_ready_i = 1'b0; flush_i = 1'b0;
      step(); step();
      reset = 1'b0;
      #1;
      // Reset state
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_in_ready",  32'(in_ready_o), 32'd1);
      chk("rst_alu_op",    32'(alu_op_o), 32'd0);
      chk("rst_alu_a",     alu_a_o, 32'd0);
      chk("rst_alu_b",     alu_b_o, 32'd0);
      chk("rst_result",    out_result_o, 32'd0);
      chk("rst_rd",        32'(out_rd_o), 32'd0);

      // R-type SUB 10-3
      out_ready_i = 1'b1;
      drive(2'b10, 3'b000, 1'b1, 32'd10, 32'd3, 5'd5);
      step();
      in_valid_i = 1'b0;
      chk("sub_alu_op",    32'(alu_op_o), 32'd1);
      chk("sub_alu_a",     alu_a_o, 32'd10);
      chk("sub_alu_b",     alu_b_o, 32'd3);
      chk("sub_out_valid_early", 32'(out_valid_o), 32'd0);
      step();
      chk("sub_out_valid", 32'(out_valid_o), 32'd1);
      chk("sub_result",    out_result_o, 32'd7);
      chk("sub_zero",      32'(out_zero_o), 32'd0);
      chk("sub_rd",        32'(out_rd_o), 32'd5);

      // I-type SRL with B masked to 4
      drive(2'b11, 3'b101, 1'b0, 32'd1, 32'h0000_0024, 5'd7);
      step();
      in_valid_i = 1'b0;
      chk("srl_alu_op",    32'(alu_op_o), 32'd6);
      chk("srl_alu_b",     alu_b_o, 32'd4);
      step();
      chk("srl_out_valid", 32'(out_valid_o), 32'd1);
      chk("srl_result",    out_result_o, 32'd0);
      chk("srl_zero",      32'(out_zero_o), 32'd1);
      chk("srl_rd",        32'(out_rd_o), 32'd7);
      step();
      chk("srl_drained",   32'(out_valid_o), 32'd0);

      // I-type 000 with f7b5 set is still ADD
      drive(2'b11, 3'b000, 1'b1, 32'd5, 32'd6, 5'd8);
      step();
      in_valid_i = 1'b0;
      chk("addi_alu_op",   32'(alu_op_o), 32'd0);
      step();
      chk("addi_result",   out_result_o, 32'd11);
      step();

      // Back-to-back stream with a 3-cycle downstream stall
      q_res.delete(); q_rd.delete();
      drive(2'b10, 3'b111, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 5'd1);  // AND
      step();
      drive(2'b10, 3'b110, 1'b0, 32'h0F, 32'hF0, 5'd2);                // OR
      out_ready_i = 1'b0;
      #1;
      chk("b2b_ready_s2_empty", 32'(in_ready_o), 32'd1);
      step();
      drive(2'b10, 3'b001, 1'b0, 32'd1, 32'h21, 5'd3);                 // SLL
      #1;
      chk("b2b_ready_full",     32'(in_ready_o), 32'd0);
      step();
      chk("b2b_hold_valid",     32'(out_valid_o), 32'd1);
      chk("b2b_hold_result",    out_result_o, 32'h0000_F000);
      chk("b2b_hold_ready",     32'(in_ready_o), 32'd0);
      step();
      chk("b2b_hold2_result",   out_result_o, 32'h0000_F000);
      chk("b2b_hold2_rd",       32'(out_rd_o), 32'd1);
      out_ready_i = 1'b1;
      #1;
      chk("b2b_ready_resume",   32'(in_ready_o), 32'd1);
      step();
      chk("b2b_sll_alu_op",     32'(alu_op_o), 32'd5);
      chk("b2b_sll_alu_b",      alu_b_o, 32'd1);
      drive(2'b00, 3'b111, 1'b1, 32'd100, 32'd23, 5'd4);               // class ADD
      step();
      in_valid_i = 1'b0;
      step(); step(); step();
      chk("b2b_count", 32'(q_res.size()), 32'd4);
      if (q_res.size() == 4) begin
         chk("b2b_res0", q_res[0], 32'h0000_F000);
         chk("b2b_res1", q_res[1], 32'h0000_00FF);
         chk("b2b_res2", q_res[2], 32'd2);
         chk("b2b_res3", q_res[3], 32'd123);
         chk("b2b_rd0",  32'(q_rd[0]), 32'd1);
         chk("b2b_rd3",  32'(q_rd[3]), 32'd4);
      end

      // Flush with S1 full and a new input offered
      q_res.delete(); q_rd.delete();
      out_ready_i = 1'b0;
      drive(2'b00, 3'b000, 1'b0, 32'd1, 32'd1, 5'd10);
      step();
      drive(2'b00, 3'b000, 1'b0, 32'd3, 32'd3, 5'd11);
      step();
      drive(2'b00, 3'b000, 1'b0, 32'd7, 32'd7, 5'd12);
      flush_i = 1'b1;
      out_ready_i = 1'b1;
      step();
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      #1;
      chk("flush_out_valid", 32'(out_valid_o), 32'd0);
      chk("flush_alu_a",     alu_a_o, 32'd0);
      chk("flush_in_ready",  32'(in_ready_o), 32'd1);
      step(); step();
      chk("flush_count", 32'(q_res.size()), 32'd1);
      if (q_res.size() == 1) begin
         chk("flush_res", q_res[0], 32'd2);
         chk("flush_rd",  32'(q_rd[0]), 32'd10);
      end

      // Illegal R-type funct3 010
      drive(2'b10, 3'b010, 1'b0, 32'd4, 32'd5, 5'd9);
      step();
      in_valid_i = 1'b0;
      chk("ill_alu_op", 32'(alu_op_o), 32'd0);
      step();
      chk("ill_out_valid", 32'(out_valid_o), 32'd1);
`ifdef ILLEGAL_OP_TRAP_EN
      chk("ill_result", out_result_o, 32'd0);
      chk("ill_flag",   32'(illegal_o), 32'd1);
`else
      chk("ill_result", out_result_o, 32'd9);
`endif
      step();

      // Reset with both stages full overrides flush/valid
      out_ready_i = 1'b0;
      drive(2'b01, 3'b000, 1'b0, 32'd9, 32'd4, 5'd20);
      step();
      drive(2'b01, 3'b000, 1'b0, 32'd8, 32'd2, 5'd21);
      step();
      chk("prerst_out_valid", 32'(out_valid_o), 32'd1);
      chk("prerst_result",    out_result_o, 32'd5);
      chk("prerst_alu_op",    32'(alu_op_o), 32'd1);
      chk("prerst_in_ready",  32'(in_ready_o), 32'd0);
      reset = 1'b1;
      flush_i = 1'b1;
      step();
      chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
      chk("midrst_alu_op",    32'(alu_op_o), 32'd0);
      chk("midrst_in_ready",  32'(in_ready_o), 32'd1);
      chk("midrst_result",    out_result_o, 32'd0);
      reset = 1'b0;
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      step();
      chk("postrst_out_valid", 32'(out_valid_o), 32'd0);
      chk("postrst_alu_a",     alu_a_o, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ex_issue_stage.md
EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have in_valid_i/in_ready_o, input/output, 1 each, upstream (ID/EX) handshake.
REQ-004 SHALL have alu_ctrl_i, input, 2, class: 00 add (load/store), 01 sub (branch), 10 R-type, 11 I-type.
REQ-005 SHALL have funct3_i (3), funct7b5_i (1), rd_i (5), rs1_val_i (32), op2_val_i (32), all inputs.
REQ-006 SHALL have alu_op_o (4), alu_a_o (32), alu_b_o (32) outputs driving the external ALU; alu_result_i (32) and alu_zero_i (1) inputs from it.
REQ-007 SHALL have out_valid_o/out_ready_i, output/input, 1 each, downstream (EX/MEM) handshake.
REQ-008 SHALL have out_result_o (32), out_zero_o (1), out_rd_o (5) outputs.
REQ-009 SHALL have flush_i, input, 1, discards the issue-register entry.

Function
REQ-010 SHALL use ALU codes ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6.
REQ-011 SHALL decode alu_ctrl 00->ADD, 01->SUB irrespective of funct fields.
REQ-012 SHALL decode R-type funct3/f7b5: 000/0 ADD, 000/1 SUB, 111 AND, 110 OR, 100 XOR, 001/0 SLL, 101/0 SRL.
REQ-013 SHALL decode I-type identically except 000 is always ADD; f7b5 ignored for AND/OR/XOR.
REQ-014 SHALL map every other combination to ADD and mark it illegal.
REQ-015 SHALL hold two stages: S1 issue register (op, A, B, rd, illegal), S2 result register (result, zero, rd).
REQ-016 SHALL drive alu_op_o/alu_a_o/alu_b_o from S1 only; zero when S1 invalid.
REQ-017 SHALL mask alu_b_o to bits [4:0] (upper bits 0) for SLL/SRL.
REQ-018 SHALL assert in_ready_o = !s1_valid || s1_adv, where s1_adv = !s2_valid || out_ready_i.
REQ-019 SHALL give latency 2: accepted at edge N -> out_valid_o high in cycle after edge N+1 when unstalled.
REQ-020 SHALL sustain one transfer per cycle with out_ready_i held high.
REQ-021 SHALL hold out_* stable while out_valid_o && !out_ready_i.
REQ-022 SHALL on flush_i clear S1 valid, not affect S2, and block acceptance that cycle (flush wins over accept).
REQ-023 SHALL, on S1->S2 advance, capture alu_result_i, alu_zero_i, rd in the same edge.

Reset
REQ-024 SHALL on reset clear S1/S2 valid, in_ready_o=1 after reset released, out_valid_o=0, all out_* and alu_* outputs 0.
REQ-025 SHALL let reset override flush_i, in_valid_i, and any in-flight transfer.

Configuration
REQ-026 SHALL, with ILLEGAL_OP_TRAP_EN defined, add output illegal_o (1) asserted with out_valid_o for entries marked illegal, result forced to 0.
REQ-027 SHALL, without ILLEGAL_OP_TRAP_EN, omit illegal_o and pass the ADD result unchanged.

Structure
REQ-028 SHALL place ALU opcode localparams and alu_ctrl class encodings in shared package alu_pkg, also used by ALU.
REQ-029 SHALL isolate decode in combinational sub-module alu_op_decode.

Verification
REQ-030 R-type 000/1, A=10, B=3, out_ready=1 -> alu_op_o=1 one cycle later, out_result=7, zero=0, two cycles after accept.
REQ-031 I-type 101/0, B=0x0000_0024, A=1 -> alu_b_o=4, result=0 (SRL), zero=1.
REQ-032 Back-to-back 4 ops, out_ready low 3 cycles mid-stream -> in_ready_o drops when both stages full, no loss/duplication, order preserved.
REQ-033 flush_i with in_valid_i and S1 full -> S1 entry never appears at output, new input not accepted, S2 entry delivered.
REQ-034 R-type 010 with ILLEGAL_OP_TRAP_EN -> illegal_o=1, result=0; without macro -> ADD result.
REQ-035 reset asserted with both stages full -> next cycle out_valid_o=0, alu_op_o=0, in_ready_o=1.
